// File: rtl/edsac_ccu_pkg.sv
// ============================================================================
//  Module      : edsac_ccu_pkg
//  Description : Shared order encodings, sequencer state type and default
//                word lengths for the CCU multiply/shift sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package edsac_ccu_pkg;

  // Order codes as delivered by the order decoder
  localparam logic [1:0] ORD_V   = 2'b00;  // multiply and add
  localparam logic [1:0] ORD_N   = 2'b01;  // multiply and subtract
  localparam logic [1:0] ORD_SHR = 2'b10;  // shift right
  localparam logic [1:0] ORD_SHL = 2'b11;  // shift left

  // Default multiplier lengths (short and long word)
  localparam int DEF_SHORT_BITS = 17;
  localparam int DEF_LONG_BITS  = 35;

  // Sequencer states; ST_ROUND is only reachable with the rounding feature
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } ccu_state_t;

  // Multiply orders have a zero MSB in the order code
  function automatic logic is_mul_order(input logic [1:0] ord);
    return ~ord[1];
  endfunction

endpackage

`default_nettype wire

// File: rtl/ccu_step_counter.sv
// ============================================================================
//  Module      : ccu_step_counter
//  Description : Step counter for the CCU sequencer. Loaded with a step total,
//                it asserts step for exactly that many cycles, counting from 0
//                up to total-1, and flags the final step.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ccu_step_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] total,
  output logic             step,
  output logic             last_step,
  output logic             done_next
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] total_q;
  logic             active_q;
  logic             w_at_last;

  // Final count reached when the counter equals total-1
  assign w_at_last = (cnt_q == (total_q - CNT_W'(1)));

  // Counter register: load restarts from 0, the last step returns to inactive
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      total_q  <= '0;
      active_q <= 1'b0;
    end else if (load) begin
      cnt_q    <= '0;
      total_q  <= total;
      active_q <= (total != '0);
    end else if (active_q) begin
      if (w_at_last) begin
        cnt_q    <= '0;
        active_q <= 1'b0;
      end else begin
        cnt_q    <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign step      = active_q;
  assign last_step = active_q & w_at_last;
  // Run phase ends after this cycle: either the final step, or a zero-length load
  assign done_next = last_step | (load & (total == '0));

endmodule

`default_nettype wire

// File: rtl/ccu_mul_shift_seq.sv
// ============================================================================
//  Module      : ccu_mul_shift_seq
//  Description : Clocked CCU multiply/shift sequencer. Steps V/N multiplies
//                and left/right shifts over a programmable number of cycles,
//                driving the complementer gates, accumulator shift gate and
//                sign propagation, and ends each order with a one-cycle ep.
//  Config      : define CCU_MUL_ROUND_EN to add a one-cycle rounding state
//                (round_pulse) after the last multiply step.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ccu_mul_shift_seq
  import edsac_ccu_pkg::*;
#(
  parameter int SHORT_BITS = DEF_SHORT_BITS,
  parameter int LONG_BITS  = DEF_LONG_BITS,
  parameter int CNT_W      = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       order,
  input  logic             long_word,
  input  logic [CNT_W-1:0] shift_cnt,
  input  logic             acc_sign,
  input  logic             mplier_bit,
  output logic             busy,
  output logic             step,
  output logic             g4_pos,
  output logic             g4_neg,
  output logic             g5,
  output logic             shift_left,
  output logic             ones2,
  output logic             round_pulse,
  output logic             ep
);

  localparam logic [CNT_W-1:0] C_SHORT = CNT_W'(SHORT_BITS);
  localparam logic [CNT_W-1:0] C_LONG  = CNT_W'(LONG_BITS);

  ccu_state_t       state_q, state_d;
  logic [1:0]       order_q;
  logic             sign_ff_q;

  logic             w_accept;
  logic [CNT_W-1:0] w_total;
  logic             w_step;
  logic             w_last_step;
  logic             w_done_next;
  logic             w_is_mul;
  logic             w_sub;

  // Orders are only accepted while idle; starts at any other time are dropped
  assign w_accept = start & (state_q == ST_IDLE);

  // Step total: word length for multiplies, clamped distance for shifts
  always_comb begin
    w_total = '0;
    if (is_mul_order(order)) begin
      w_total = long_word ? C_LONG : C_SHORT;
    end else begin
      w_total = (shift_cnt > C_LONG) ? C_LONG : shift_cnt;
    end
  end

  ccu_step_counter #(
    .CNT_W (CNT_W)
  ) u_step_counter (
    .clk       (clk),
    .rst       (rst),
    .load      (w_accept),
    .total     (w_total),
    .step      (w_step),
    .last_step (w_last_step),
    .done_next (w_done_next)
  );

  // State, latched order and sign register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      order_q   <= 2'b00;
      sign_ff_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (w_accept) begin
        order_q   <= order;
        sign_ff_q <= acc_sign;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = w_done_next ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_done_next) begin
`ifdef CCU_MUL_ROUND_EN
          state_d = is_mul_order(order_q) ? ST_ROUND : ST_DONE;
`else
          state_d = ST_DONE;
`endif
        end
      end
      ST_ROUND: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign w_is_mul = is_mul_order(order_q);
  // The final multiplier digit carries negative weight, flipping add/subtract
  assign w_sub    = (order_q == ORD_N) ^ w_last_step;

  assign busy       = (state_q != ST_IDLE);
  assign step       = w_step;
  assign g4_pos     = w_step & w_is_mul & mplier_bit & ~w_sub;
  assign g4_neg     = w_step & w_is_mul & mplier_bit &  w_sub;
  assign g5         = w_step;
  assign shift_left = w_step & (order_q == ORD_SHL);
  assign ones2      = w_step & (order_q == ORD_SHR) & sign_ff_q;
  assign ep         = (state_q == ST_DONE);

`ifdef CCU_MUL_ROUND_EN
  assign round_pulse = (state_q == ST_ROUND);
`else
  assign round_pulse = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ccu_mul_shift_seq.sv
// ============================================================================
//  Module      : tb_ccu_mul_shift_seq
//  Description : Self-checking bench for ccu_mul_shift_seq. Directed orders
//                followed by randomized ones, checked cycle by cycle against
//                a behavioural model of the order timing and gate rules.
//  Config      : honours CCU_MUL_ROUND_EN for the rounding cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ccu_mul_shift_seq;

  localparam int CNT_W = 6;
  localparam int SHORT = 17;
  localparam int LONG  = 35;
`ifdef CCU_MUL_ROUND_EN
  localparam bit ROUND_ON = 1'b1;
`else
  localparam bit ROUND_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [1:0]       order = 2'b00;
  logic             long_word = 1'b0;
  logic [CNT_W-1:0] shift_cnt = '0;
  logic             acc_sign = 1'b0;
  logic             mplier_bit = 1'b0;
  logic busy, step, g4_pos, g4_neg, g5, shift_left, ones2, round_pulse, ep;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ccu_mul_shift_seq #(
    .SHORT_BITS (SHORT),
    .LONG_BITS  (LONG),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .order       (order),
    .long_word   (long_word),
    .shift_cnt   (shift_cnt),
    .acc_sign    (acc_sign),
    .mplier_bit  (mplier_bit),
    .busy        (busy),
    .step        (step),
    .g4_pos      (g4_pos),
    .g4_neg      (g4_neg),
    .g5          (g5),
    .shift_left  (shift_left),
    .ones2       (ones2),
    .round_pulse (round_pulse),
    .ep          (ep)
  );

  // Output vector order: busy step g4_pos g4_neg g5 shift_left ones2 round_pulse ep
  function automatic logic [8:0] outv();
    return {busy, step, g4_pos, g4_neg, g5, shift_left, ones2, round_pulse, ep};
  endfunction

  task automatic check_eq(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b (busy step g4p g4n g5 shl ones2 rnd ep)",
               tag, obs, exp);
    end
  endtask

  // Advance one cycle: drive after the rising edge, then let outputs settle
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Runs one order and checks every cycle from the start strobe to the idle
  // cycle after ep.  mpat: 0 random digits, 1 digits 1,0,1 then zeros,
  // 2 all ones.  rst_at>0 aborts with reset on that step.  poke pulses
  // extra starts during the run and on the ep cycle.
  task automatic run_order(input string name, input logic [1:0] ord, input logic lw,
                           input int sc, input logic sg, input int mpat,
                           input int rst_at, input bit poke);
    bit   is_mul;
    int   n;
    logic m, sub;
    logic [8:0] e;
    is_mul = (ord == 2'b00) || (ord == 2'b01);
    n = is_mul ? (lw ? LONG : SHORT) : ((sc > LONG) ? LONG : sc);

    // Start cycle: still idle, so everything is low
    next_cycle();
    start = 1'b1; order = ord; long_word = lw; shift_cnt = CNT_W'(sc);
    acc_sign = sg; mplier_bit = 1'($urandom);
    #4 check_eq({name, ":start"}, outv(), 9'b0);

    for (int k = 1; k <= n; k++) begin
      next_cycle();
      start      = poke && (k == 2 || k == n);
      order      = 2'($urandom);
      long_word  = 1'($urandom);
      shift_cnt  = CNT_W'($urandom);
      acc_sign   = 1'($urandom);
      case (mpat)
        1:       m = (k == 1 || k == 3);
        2:       m = 1'b1;
        default: m = 1'($urandom);
      endcase
      mplier_bit = m;
      if (k == rst_at) rst = 1'b1;
      sub = (ord == 2'b01) ^ (k == n);
      e = {1'b1, 1'b1,
           1'(is_mul && m && !sub), 1'(is_mul && m && sub),
           1'b1, 1'(ord == 2'b11), 1'(ord == 2'b10 && sg), 1'b0, 1'b0};
      #4 check_eq($sformatf("%s:step%0d", name, k), outv(), e);
      if (k == rst_at) begin
        for (int j = 0; j < 4; j++) begin
          next_cycle();
          rst = 1'b0;
          start = 1'b0;
          #4 check_eq($sformatf("%s:abort%0d", name, j), outv(), 9'b0);
        end
        return;
      end
    end

    if (ROUND_ON && is_mul) begin
      next_cycle();
      start = 1'b0;
      #4 check_eq({name, ":round"}, outv(), 9'b1_0000_0010);
    end

    // End pulse; a coincident start must be ignored
    next_cycle();
    start = poke;
    order = 2'b00;
    #4 check_eq({name, ":ep"}, outv(), 9'b1_0000_0001);

    next_cycle();
    start = 1'b0;
    #4 check_eq({name, ":idle"}, outv(), 9'b0);
  endtask

  initial begin
    repeat (3) next_cycle();
    #4 check_eq("reset", outv(), 9'b0);
    rst = 1'b0;
    next_cycle();
    #4 check_eq("post_reset", outv(), 9'b0);

    run_order("v_short_101",  2'b00, 1'b0, 0,  1'b0, 1, 0, 1'b0);
    run_order("n_long_ones",  2'b01, 1'b1, 0,  1'b0, 2, 0, 1'b0);
    run_order("shr5_sign1",   2'b10, 1'b0, 5,  1'b1, 0, 0, 1'b0);
    run_order("shr5_sign0",   2'b10, 1'b0, 5,  1'b0, 0, 0, 1'b0);
    run_order("shl0",         2'b11, 1'b0, 0,  1'b0, 0, 0, 1'b0);
    run_order("shl63_clamp",  2'b11, 1'b0, 63, 1'b0, 0, 0, 1'b0);
    run_order("v_poke",       2'b00, 1'b1, 0,  1'b0, 0, 0, 1'b1);
    run_order("shr_poke",     2'b10, 1'b0, 7,  1'b1, 0, 0, 1'b1);
    run_order("v_rst10",      2'b00, 1'b0, 0,  1'b0, 2, 10, 1'b0);
    run_order("n_short",      2'b01, 1'b0, 0,  1'b0, 2, 0, 1'b0);
    run_order("shr35_exact",  2'b10, 1'b0, 35, 1'b1, 0, 0, 1'b0);
    run_order("shl36_clamp",  2'b11, 1'b0, 36, 1'b0, 0, 0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      run_order($sformatf("rnd%0d", i), 2'($urandom), 1'($urandom),
                int'($urandom_range(0, 63)), 1'($urandom), 0, 0, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
